// File: rtl/pbit_sampler.sv
// Probabilistic-bit update stage: spin = sign(beta*field + random), 3-stage valid/ready pipe,
// plus a windowed ones-counter that reports a running magnetisation estimate.
module pbit_sampler #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      field_in,
  input  logic [7:0]       beta_in,
  input  logic [31:0]      rnd_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             spin_out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clear,
  output logic [CNT_W-1:0] avg_count,
  output logic             avg_valid
);

  localparam int unsigned PROD_W = 25;
  localparam int unsigned X_W    = 16;
  localparam int unsigned SUM_W  = X_W + 1;

  logic                     adv;
  logic                     xfer;
  logic                     s1_v;
  logic                     s2_v;
  logic signed [PROD_W-1:0] s1_prod;
  logic signed [X_W-1:0]    s1_r;
  logic signed [X_W-1:0]    s2_x;
  logic signed [X_W-1:0]    s2_r;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] shr_c;
  logic signed [X_W-1:0]    x_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic                     spin_c;
  logic [CNT_W-1:0]         tcnt;
  logic [CNT_W-1:0]         ones;
  logic                     rnd_lo_unused;

  // Only the upper half of the LFSR word is consumed.
  assign rnd_lo_unused = ^rnd_in[15:0];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign xfer     = out_valid & out_ready;

  // Q4.12 * Q4.4 -> Q8.16; beta is zero-extended so it stays non-negative.
  assign prod_c = PROD_W'($signed(field_in)) * PROD_W'($signed({1'b0, beta_in}));

  // Rescale to Q.15 and clamp into the 16-bit signed range.
  always_comb begin
    shr_c = s1_prod >>> 1;
    x_c   = shr_c[X_W-1:0];
    if (!shr_c[PROD_W-1] && (|shr_c[PROD_W-2:X_W-1])) begin
      x_c = 16'sh7FFF;
    end else if (shr_c[PROD_W-1] && !(&shr_c[PROD_W-2:X_W-1])) begin
      x_c = 16'sh8000;
    end
  end

  assign sum_c  = SUM_W'(s2_x) + SUM_W'(s2_r);
  assign spin_c = (sum_c >= SUM_W'(0));

  // All three stages advance together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      spin_out  <= 1'b0;
      s1_prod   <= '0;
      s1_r      <= '0;
      s2_x      <= '0;
      s2_r      <= '0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_prod   <= prod_c;
      s1_r      <= rnd_in[31:16];
      s2_v      <= s1_v;
      s2_x      <= x_c;
      s2_r      <= s1_r;
      out_valid <= s2_v;
      spin_out  <= spin_c;
    end
  end

  // Window accumulator; clear wins over a concurrent transfer and leaves avg_count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt      <= '0;
      ones      <= '0;
      avg_count <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (clear) begin
        tcnt <= '0;
        ones <= '0;
      end else if (xfer) begin
        if (tcnt == CNT_W'(WINDOW - 1)) begin
          avg_count <= ones + CNT_W'(spin_out);
          avg_valid <= 1'b1;
          tcnt      <= '0;
          ones      <= '0;
        end else begin
          tcnt <= tcnt + CNT_W'(1);
          ones <= ones + CNT_W'(spin_out);
        end
      end
    end
  end

endmodule
